// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART/ALU sequencer: state encoding, default
// widths and the opcode constants used by the ALU and its surroundings.
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the receiver, ALU and transmitter signals around the sequencer.
// master: the sequencer itself. slave: the UART/ALU side.
interface uart_alu_ctrl_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
);

  logic               rx_done_tick;
  logic [NB_DATA-1:0] rx_data;
  logic [NB_DATA-1:0] alu_result;
  logic               tx_done_tick;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               overrun;
  logic               timeout;

  modport master (
    input  rx_done_tick, rx_data, alu_result, tx_done_tick,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout
  );

  modport slave (
    output rx_done_tick, rx_data, alu_result, tx_done_tick,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout
  );

endinterface

// File: rtl/uart_alu_ctrl_timeout.sv
// Inter-byte timeout counter. Reloads on clr, counts down while en is high,
// and flags term while enabled at zero.
module uart_alu_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Reload on each accepted byte, otherwise count down to zero while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = en && (cnt == '0);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART receiver, ALU and UART transmitter.
// Collects A, B, opcode; launches the result to the transmitter; waits for
// completion. Optional inter-byte timeout under UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic            clk,
  input logic            reset,
  uart_alu_ctrl_if.master bus
);

  state_t             state;
  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               overrun_q;
  logic               timeout_q;
  logic               tmo_hit;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  assign tmo_clr = bus.rx_done_tick &&
                   ((state == GET_A) || (state == GET_B) || (state == GET_OP));
  assign tmo_en  = (state == GET_B) || (state == GET_OP);

  uart_alu_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .term (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GET_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        GET_A: begin
          if (bus.rx_done_tick) begin
            alu_a_q <= bus.rx_data;
            state   <= GET_B;
            busy_q  <= 1'b1;
          end
        end
        GET_B: begin
          if (bus.rx_done_tick) begin
            alu_b_q <= bus.rx_data;
            state   <= GET_OP;
          end else if (tmo_hit) begin
            state     <= GET_A;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        GET_OP: begin
          if (bus.rx_done_tick) begin
            alu_op_q <= bus.rx_data[NB_OP-1:0];
            state    <= EXEC;
          end else if (tmo_hit) begin
            state     <= GET_A;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        EXEC: begin
          tx_data_q  <= bus.alu_result;
          tx_start_q <= 1'b1;
          state      <= WAIT_TX;
          overrun_q  <= bus.rx_done_tick;
        end
        WAIT_TX: begin
          overrun_q <= bus.rx_done_tick;
          if (bus.tx_done_tick) begin
            state  <= GET_A;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= GET_A;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign bus.timeout  = timeout_q;

endmodule
